pcie_ts_rx_detect: RTL and testbench
====================================

PCIE_TS_RX_DETECT -- requirements
Module: pcie_ts_rx_detect

Interface
REQ-001 Parameter CONSEC_MAX, default 15, saturation value of the consecutive-TS counter (minimum 8).
REQ-002 clk_i  input  1  single clock; all logic is on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 sym_i  input  8  decoded Gen1/Gen2 lane symbol.
REQ-005 sym_k_i  input  1  1 = sym_i is a K character.
REQ-006 sym_valid_i  input  1  sym_i and sym_k_i qualify this cycle; low = stall, no symbol consumed.
REQ-007 cnt_clr_i  input  1  clears the consecutive counter (used on LTSSM state change).
REQ-008 ts_valid_o  output  1  one-cycle pulse: a well-formed TS1/TS2 was received.
REQ-009 ts_type_o  output  1  0 = TS1 (0x4A), 1 = TS2 (0x45).
REQ-010 link_num_o, lane_num_o  output  8 each  symbols 1 and 2.
REQ-011 link_pad_o, lane_pad_o  output  1 each  the corresponding symbol was K PAD (0xF7).
REQ-012 n_fts_o  output  8  symbol 3.
REQ-013 rate_id_o  output  8  symbol 4, typed as rate_id_t.
REQ-014 train_ctrl_o  output  8  symbol 5, typed as training_ctrl_t.
REQ-015 consec_cnt_o  output  4  count of consecutive identical TSs, saturating at CONSEC_MAX.
REQ-016 ts_err_o  output  1  one-cycle pulse: the ordered set was malformed.

Function
REQ-017 FSM states: HUNT and COLLECT; a 4-bit index idx tracks the symbol position 1..15.
- Only cycles with sym_valid_i=1 advance the FSM or idx.
- Stalls of any length are transparent.
REQ-018 HUNT to COLLECT, idx=1: on K COM (0xBC); every other symbol is silently discarded in HUNT.
REQ-019 Symbols 1-2 accepted: data of any value, or K PAD; any other K is an error.
REQ-020 Symbols 3-5 must be data (sym_k_i=0); a K here is an error.
REQ-021 Symbol 6: must be data 0x4A or 0x45; this latches the TS type.
REQ-022 Symbols 7-15: must be data equal to the latched identifier.
REQ-023 On error: ts_err_o pulses in the next cycle and the FSM returns to HUNT.
- If the offending symbol is K COM, the FSM instead goes to COLLECT with idx=1 (re-sync without loss).
REQ-024 Successful TS: accepting symbol 15 registers all field outputs and pulses ts_valid_o in the next cycle (latency 1 cycle after symbol 15); the FSM then returns to HUNT.
REQ-025 Field outputs hold their last valid value until the next ts_valid_o; they do not change on error.
REQ-026 Consecutive counter on ts_valid_o:
- The new TS is compared with the previous valid TS on type, link, lane, pad flags, n_fts, rate_id and train_ctrl.
- Equal: the counter increments, saturating at CONSEC_MAX.
- Different, or first TS after clear/error: the counter is set to 1.
REQ-027 ts_err_o sets the counter to 0.
REQ-028 cnt_clr_i sets the counter to 0.
- cnt_clr_i in the same cycle as ts_valid_o: the counter becomes 1 and the compare history is replaced.
- cnt_clr_i in the same cycle as ts_err_o: the counter becomes 0.
REQ-029 ts_valid_o and ts_err_o are never high in the same cycle.
REQ-030 The next COM can be accepted in the cycle directly after symbol 15, so back-to-back TSs with no gap are supported.

Reset
REQ-031 rst_i asynchronously forces:
- state HUNT and idx=0;
- ts_valid_o=0, ts_err_o=0 and consec_cnt_o=0;
- all field outputs and pad flags to 0;
- compare history invalid.
REQ-032 Reset asserted mid-set discards the partial ordered set; no pulse is produced after reset releases.

Structure
REQ-033 These typedefs come from pcie_phy_pkg: train_seq_e, phy_layer_special_symbols_e, rate_id_t and training_ctrl_t.
REQ-034 Add the following to pcie_phy_pkg:
- ts_type_e (TS1_T, TS2_T);
- a packed ts_rx_fields_t record;
- localparam TsLen = 16.
REQ-035 The block is a single module with no sub-module.

Verification
REQ-036 Send COM, K PAD, K PAD, 0x1F, 0x02, 0x00, then 10x 0x4A, eight times back-to-back.
- Required: eight ts_valid_o pulses, ts_type_o=0, link_pad_o=1, n_fts_o=0x1F.
- Required: consec_cnt_o steps 1..8.
REQ-037 Send TS2 with link 0x00, lane 0x03, with sym_valid_i low every other cycle.
- Required: ts_valid_o one cycle after symbol 15, ts_type_o=1, lane_num_o=0x03.
REQ-038 Send a TS1 with symbol 11 = 0x45.
- Required: ts_err_o pulse, consec_cnt_o=0, field outputs unchanged.
REQ-039 Send a COM at symbol position 9, followed by a full TS1.
- Required: ts_err_o, then ts_valid_o for the re-synced set.
REQ-040 Send 16 identical TS1s.
- Required: consec_cnt_o saturates at 15.
- Then send a TS1 with n_fts 0x20: required consec_cnt_o=1.
- Assert cnt_clr_i coincident with a ts_valid_o: required consec_cnt_o=1.
REQ-041 Assert rst_i at symbol 7.
- Required: all outputs 0 immediately, and no pulse after release until a complete new TS arrives.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY symbol definitions and training-set receive record.
package pcie_phy_pkg;

  localparam int unsigned SymW  = 8;
  localparam int unsigned TsLen = 16;

  typedef enum logic [7:0] {
    TS1_ID = 8'h4A,
    TS2_ID = 8'h45
  } train_seq_e;

  typedef enum logic [7:0] {
    K_COM = 8'hBC,
    K_STP = 8'hFB,
    K_SDP = 8'h5C,
    K_END = 8'hFD,
    K_EDB = 8'hFE,
    K_PAD = 8'hF7,
    K_SKP = 8'h1C,
    K_FTS = 8'h3C,
    K_IDL = 8'h7C,
    K_EIE = 8'hFC
  } phy_layer_special_symbols_e;

  // TS symbol 4: data rate identifier
  typedef struct packed {
    logic       speed_change;
    logic       autonomous_change;
    logic [1:0] rsvd_hi;
    logic       rate_8g;
    logic       rate_5g;
    logic       rate_2g5;
    logic       rsvd_lo;
  } rate_id_t;

  // TS symbol 5: training control
  typedef struct packed {
    logic [2:0] rsvd;
    logic       compliance_receive;
    logic       disable_scrambling;
    logic       loopback;
    logic       disable_link;
    logic       hot_reset;
  } training_ctrl_t;

  typedef enum logic {
    TS1_T = 1'b0,
    TS2_T = 1'b1
  } ts_type_e;

  typedef struct packed {
    ts_type_e         ts_type;
    logic [SymW-1:0]  link_num;
    logic             link_pad;
    logic [SymW-1:0]  lane_num;
    logic             lane_pad;
    logic [SymW-1:0]  n_fts;
    rate_id_t         rate_id;
    training_ctrl_t   train_ctrl;
  } ts_rx_fields_t;

endpackage

// File: rtl/pcie_ts_rx_detect.sv
// Receive-side TS1/TS2 ordered-set detector: validates the 16-symbol set,
// extracts its fields and counts consecutive identical sets.
module pcie_ts_rx_detect
  import pcie_phy_pkg::*;
#(
  parameter int unsigned CONSEC_MAX = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [7:0]     sym_i,
  input  logic           sym_k_i,
  input  logic           sym_valid_i,
  input  logic           cnt_clr_i,
  output logic           ts_valid_o,
  output logic           ts_type_o,
  output logic [7:0]     link_num_o,
  output logic [7:0]     lane_num_o,
  output logic           link_pad_o,
  output logic           lane_pad_o,
  output logic [7:0]     n_fts_o,
  output rate_id_t       rate_id_o,
  output training_ctrl_t train_ctrl_o,
  output logic [3:0]     consec_cnt_o,
  output logic           ts_err_o
);

  localparam logic [3:0] CntMax  = 4'(CONSEC_MAX);
  localparam logic [3:0] LastIdx = 4'(TsLen - 1);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  ts_rx_fields_t acc_q, acc_d;
  ts_rx_fields_t fields_q, fields_d;
  logic          hist_vld_q, hist_vld_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic       is_com;
  logic       bad;
  logic       done;
  logic [7:0] exp_id;

  assign is_com = sym_k_i && (sym_i == K_COM);
  assign exp_id = (acc_q.ts_type == TS2_T) ? TS2_ID : TS1_ID;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      acc_q      <= '0;
      fields_q   <= '0;
      hist_vld_q <= 1'b0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      fields_q   <= fields_d;
      hist_vld_q <= hist_vld_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    fields_d   = fields_q;
    hist_vld_d = hist_vld_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    bad        = 1'b0;
    done       = 1'b0;

    if (sym_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (is_com) begin
            state_d = COLLECT;
            idx_d   = 4'd1;
            acc_d   = '0;
          end
        end
        COLLECT: begin
          if (idx_q <= 4'd2) begin
            if (sym_k_i && (sym_i != K_PAD)) begin
              bad = 1'b1;
            end else if (idx_q == 4'd1) begin
              acc_d.link_num = sym_i;
              acc_d.link_pad = sym_k_i;
            end else begin
              acc_d.lane_num = sym_i;
              acc_d.lane_pad = sym_k_i;
            end
          end else if (idx_q <= 4'd5) begin
            if (sym_k_i) begin
              bad = 1'b1;
            end else if (idx_q == 4'd3) begin
              acc_d.n_fts = sym_i;
            end else if (idx_q == 4'd4) begin
              acc_d.rate_id = rate_id_t'(sym_i);
            end else begin
              acc_d.train_ctrl = training_ctrl_t'(sym_i);
            end
          end else if (idx_q == 4'd6) begin
            if (sym_k_i || ((sym_i != TS1_ID) && (sym_i != TS2_ID))) begin
              bad = 1'b1;
            end else begin
              acc_d.ts_type = (sym_i == TS2_ID) ? TS2_T : TS1_T;
            end
          end else if (sym_k_i || (sym_i != exp_id)) begin
            bad = 1'b1;
          end

          // A COM that breaks a set starts the next one without losing it
          if (bad) begin
            err_d = 1'b1;
            if (is_com) begin
              idx_d = 4'd1;
              acc_d = '0;
            end else begin
              state_d = HUNT;
              idx_d   = '0;
            end
          end else if (idx_q == LastIdx) begin
            done     = 1'b1;
            valid_d  = 1'b1;
            fields_d = acc_q;
            state_d  = HUNT;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end

    // A clear on the completing cycle restarts the history with this set
    if (done) begin
      if (cnt_clr_i || !hist_vld_q || (acc_q != fields_q)) begin
        cnt_d = 4'd1;
      end else if (cnt_q < CntMax) begin
        cnt_d = cnt_q + 4'd1;
      end
      hist_vld_d = 1'b1;
    end else if (err_d || cnt_clr_i) begin
      cnt_d      = '0;
      hist_vld_d = 1'b0;
    end
  end

  assign ts_valid_o   = valid_q;
  assign ts_err_o     = err_q;
  assign consec_cnt_o = cnt_q;
  assign ts_type_o    = fields_q.ts_type;
  assign link_num_o   = fields_q.link_num;
  assign lane_num_o   = fields_q.lane_num;
  assign link_pad_o   = fields_q.link_pad;
  assign lane_pad_o   = fields_q.lane_pad;
  assign n_fts_o      = fields_q.n_fts;
  assign rate_id_o    = fields_q.rate_id;
  assign train_ctrl_o = fields_q.train_ctrl;

endmodule

// File: tb/tb_pcie_ts_rx_detect.sv
// Bench for pcie_ts_rx_detect: directed scenarios plus random ordered-set traffic
// checked every cycle against a symbol-queue reference model.
module tb_pcie_ts_rx_detect;
  import pcie_phy_pkg::*;

  localparam int CONSEC_MAX = 15;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [7:0]     sym_i;
  logic           sym_k_i;
  logic           sym_valid_i;
  logic           cnt_clr_i;
  logic           ts_valid_o;
  logic           ts_type_o;
  logic [7:0]     link_num_o;
  logic [7:0]     lane_num_o;
  logic           link_pad_o;
  logic           lane_pad_o;
  logic [7:0]     n_fts_o;
  rate_id_t       rate_id_o;
  training_ctrl_t train_ctrl_o;
  logic [3:0]     consec_cnt_o;
  logic           ts_err_o;

  pcie_ts_rx_detect #(.CONSEC_MAX(CONSEC_MAX)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sym_i        (sym_i),
    .sym_k_i      (sym_k_i),
    .sym_valid_i  (sym_valid_i),
    .cnt_clr_i    (cnt_clr_i),
    .ts_valid_o   (ts_valid_o),
    .ts_type_o    (ts_type_o),
    .link_num_o   (link_num_o),
    .lane_num_o   (lane_num_o),
    .link_pad_o   (link_pad_o),
    .lane_pad_o   (lane_pad_o),
    .n_fts_o      (n_fts_o),
    .rate_id_o    (rate_id_o),
    .train_ctrl_o (train_ctrl_o),
    .consec_cnt_o (consec_cnt_o),
    .ts_err_o     (ts_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec;
  int unsigned n_mis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: symbols after COM are queued and judged by position
  bit          m_in;
  logic [8:0]  m_buf[$];
  logic [42:0] m_last;
  bit          m_hv;
  int          m_cnt;
  bit          m_valid;
  bit          m_err;

  logic [8:0]  fr[16];

  task automatic m_reset();
    m_in = 0; m_buf.delete(); m_last = '0; m_hv = 0; m_cnt = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [8:0] sy, input bit v, input bit clr);
    bit          com;
    bit          ok;
    int          pos;
    logic [42:0] rec;
    com = sy[8] && (sy[7:0] == 8'hBC);
    m_valid = 0;
    m_err = 0;
    if (v) begin
      if (!m_in) begin
        if (com) begin m_in = 1; m_buf.delete(); end
      end else begin
        pos = m_buf.size() + 1;
        if (pos <= 2)       ok = !sy[8] || (sy[7:0] == 8'hF7);
        else if (pos <= 5)  ok = !sy[8];
        else if (pos == 6)  ok = !sy[8] && (sy[7:0] == 8'h4A || sy[7:0] == 8'h45);
        else                ok = !sy[8] && (sy[7:0] == m_buf[5][7:0]);
        if (!ok) begin
          m_err = 1; m_buf.delete(); m_in = com;
        end else begin
          m_buf.push_back(sy);
          if (pos == 15) begin m_valid = 1; m_in = 0; end
        end
      end
    end
    if (m_valid) begin
      rec = {m_buf[5][7:0] == 8'h45, m_buf[0][7:0], m_buf[0][8], m_buf[1][7:0], m_buf[1][8],
             m_buf[2][7:0], m_buf[3][7:0], m_buf[4][7:0]};
      if (clr || !m_hv || rec != m_last) m_cnt = 1;
      else if (m_cnt < CONSEC_MAX) m_cnt++;
      m_last = rec;
      m_hv = 1;
    end else if (m_err || clr) begin
      m_cnt = 0;
      m_hv = 0;
    end
  endtask

  function automatic logic [42:0] dut_rec();
    return {ts_type_o, link_num_o, link_pad_o, lane_num_o, lane_pad_o, n_fts_o,
            8'(rate_id_o), 8'(train_ctrl_o)};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(ts_valid_o), 0);
    check({tag, "_err"}, 64'(ts_err_o), 0);
    check({tag, "_cnt"}, 64'(consec_cnt_o), 0);
    check({tag, "_fields"}, 64'(dut_rec()), 0);
  endtask

  task automatic drive(input logic [8:0] sy, input bit v, input bit clr);
    sym_i = sy[7:0]; sym_k_i = sy[8]; sym_valid_i = v; cnt_clr_i = clr;
    model_step(sy, v, clr);
    @(posedge clk_i);
    #1;
    check("cyc_valid", 64'(ts_valid_o), 64'(m_valid));
    check("cyc_err", 64'(ts_err_o), 64'(m_err));
    check("cyc_cnt", 64'(consec_cnt_o), 64'(m_cnt));
    check("cyc_fields", 64'(dut_rec()), 64'(m_last));
    sym_valid_i = 0; cnt_clr_i = 0;
  endtask

  task automatic make_ts(input bit ts2, input logic [8:0] link, input logic [8:0] lane,
                         input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] tc);
    fr[0] = 9'h1BC; fr[1] = link; fr[2] = lane;
    fr[3] = {1'b0, nfts}; fr[4] = {1'b0, rate}; fr[5] = {1'b0, tc};
    for (int i = 6; i < 16; i++) fr[i] = {1'b0, ts2 ? 8'h45 : 8'h4A};
  endtask

  task automatic send_range(input int lo, input int hi, input int stall_pct, input bit alt,
                            input bit clr_last);
    for (int i = lo; i <= hi; i++) begin
      if (alt && i > lo) drive(9'($urandom), 0, 0);
      else if (stall_pct > 0 && $urandom_range(99) < stall_pct)
        repeat ($urandom_range(1, 3)) drive(9'($urandom), 0, 0);
      drive(fr[i], 1, clr_last && (i == hi));
    end
  endtask

  initial begin
    int pulses;
    int p;
    int pos;
    rst_i = 0; sym_i = 0; sym_k_i = 0; sym_valid_i = 0; cnt_clr_i = 0;
    n_vec = 0; n_mis = 0;
    m_reset();
    #2 rst_i = 1;
    #1 check_zero("rst");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;

    // Eight back-to-back padded TS1s
    make_ts(0, 9'h1F7, 9'h1F7, 8'h1F, 8'h02, 8'h00);
    for (int i = 0; i < 8; i++) begin
      send_range(0, 15, 0, 0, 0);
      check("b2b_valid", 64'(ts_valid_o), 1);
      check("b2b_cnt", 64'(consec_cnt_o), 64'(i + 1));
    end
    check("b2b_type", 64'(ts_type_o), 0);
    check("b2b_link_pad", 64'(link_pad_o), 1);
    check("b2b_nfts", 64'(n_fts_o), 64'h1F);

    // TS2 with a stall every other cycle
    make_ts(1, 9'h000, 9'h003, 8'h10, 8'h06, 8'h00);
    send_range(0, 15, 0, 1, 0);
    check("stall_valid", 64'(ts_valid_o), 1);
    check("stall_type", 64'(ts_type_o), 1);
    check("stall_lane", 64'(lane_num_o), 64'h03);
    check("stall_cnt", 64'(consec_cnt_o), 1);

    // Wrong identifier at symbol 11
    make_ts(0, 9'h001, 9'h000, 8'h33, 8'h02, 8'h00);
    fr[11] = 9'h045;
    send_range(0, 11, 0, 0, 0);
    check("badid_err", 64'(ts_err_o), 1);
    check("badid_cnt", 64'(consec_cnt_o), 0);
    check("badid_nfts_held", 64'(n_fts_o), 64'h10);
    check("badid_type_held", 64'(ts_type_o), 1);
    send_range(12, 15, 0, 0, 0);

    // COM at position 9 re-syncs onto a new set
    make_ts(0, 9'h005, 9'h001, 8'h22, 8'h02, 8'h00);
    send_range(0, 8, 0, 0, 0);
    drive(9'h1BC, 1, 0);
    check("resync_err", 64'(ts_err_o), 1);
    send_range(1, 15, 0, 0, 0);
    check("resync_valid", 64'(ts_valid_o), 1);
    check("resync_cnt", 64'(consec_cnt_o), 1);

    // Saturation, change of content, clear coincident with completion
    make_ts(0, 9'h001, 9'h002, 8'h18, 8'h02, 8'h00);
    repeat (16) send_range(0, 15, 0, 0, 0);
    check("sat_cnt", 64'(consec_cnt_o), 15);
    fr[3] = 9'h020;
    send_range(0, 15, 0, 0, 0);
    check("diff_cnt", 64'(consec_cnt_o), 1);
    send_range(0, 15, 0, 0, 1);
    check("clr_valid", 64'(ts_valid_o), 1);
    check("clr_cnt", 64'(consec_cnt_o), 1);

    // Reset at symbol 7
    send_range(0, 6, 0, 0, 0);
    sym_i = fr[7][7:0]; sym_k_i = fr[7][8]; sym_valid_i = 1;
    rst_i = 1;
    #1;
    m_reset();
    check_zero("rst_mid");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    sym_valid_i = 0;
    pulses = 0;
    for (int i = 8; i <= 15; i++) begin
      drive(fr[i], 1, 0);
      pulses += int'(ts_valid_o) + int'(ts_err_o);
    end
    check("rst_no_pulse", 64'(pulses), 0);
    send_range(0, 15, 0, 0, 0);
    check("rst_new_valid", 64'(ts_valid_o), 1);
    check("rst_new_cnt", 64'(consec_cnt_o), 1);

    // Random traffic from a small pool so repeats and saturation occur
    for (int it = 0; it < 250; it++) begin
      p = int'($urandom_range(2));
      make_ts(p == 2, (p == 0) ? 9'h1F7 : 9'h001, 9'(p), 8'(8'h1F + p), 8'h02,
              (p == 1) ? 8'h04 : 8'h00);
      case ($urandom_range(9))
        0: repeat ($urandom_range(1, 3)) drive(($urandom_range(7) == 0) ? 9'h1BC : 9'($urandom), 1, 0);
        1: drive(9'($urandom), 0, 1);
        2, 3: begin
          pos = int'($urandom_range(1, 15));
          fr[pos] = ($urandom_range(3) == 0) ? 9'h1BC : 9'($urandom);
          send_range(0, 15, 20, 0, 0);
        end
        default: send_range(0, 15, 25, 0, $urandom_range(7) == 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
